// File: rtl/dma_writeback_engine_pkg.sv
// Shared definitions for the outbound (buffer-to-DRAM) writeback DMA:
// FSM state encoding and default widths.
package dma_writeback_engine_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 16;
    localparam int DMA_LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_writeback_engine.sv
// Outbound DMA: moves xfer_len 16-bit words from the on-chip buffer to DRAM,
// one buffer read then one handshaked DRAM write per word.
// Optional running checksum of written words when DMA_WB_CHECKSUM_EN is defined.
module dma_writeback_engine
    import dma_writeback_engine_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_re,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
`ifdef DMA_WB_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic              dram_ready
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};

    dma_state_e        state_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count_r;
    logic [DATA_W-1:0] hold_r;
    logic              busy_r;
    logic              done_r;
    logic              buf_re_r;
    logic              dram_we_r;
    logic              last_word_s;

    // len_r is never zero while in WR, so len_r-1 cannot underflow there
    assign last_word_s = (count_r == (len_r - LEN_ONE));

    // Transfer FSM; control outputs are registered alongside the state they decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            src_r     <= {ADDR_W{1'b0}};
            dst_r     <= {ADDR_W{1'b0}};
            len_r     <= LEN_ZERO;
            count_r   <= LEN_ZERO;
            hold_r    <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            buf_re_r  <= 1'b0;
            dram_we_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        src_r   <= src_addr;
                        dst_r   <= dst_addr;
                        len_r   <= xfer_len;
                        count_r <= LEN_ZERO;
                        busy_r  <= 1'b1;
                        if (xfer_len == LEN_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r  <= ST_RD_REQ;
                            buf_re_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    state_r  <= ST_RD_CAP;
                    buf_re_r <= 1'b0;
                end
                ST_RD_CAP: begin
                    hold_r    <= buf_rdata;
                    state_r   <= ST_WR;
                    dram_we_r <= 1'b1;
                end
                ST_WR: begin
                    if (dram_ready) begin
                        src_r     <= src_r + ADDR_ONE;
                        dst_r     <= dst_r + ADDR_ONE;
                        count_r   <= count_r + LEN_ONE;
                        dram_we_r <= 1'b0;
                        if (last_word_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r  <= ST_RD_REQ;
                            buf_re_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_WR;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    buf_re_r  <= 1'b0;
                    dram_we_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_WB_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;
    logic              start_acc_s;
    logic              wr_acc_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign wr_acc_s    = (state_r == ST_WR) && dram_ready;

    // Modular sum of every word DRAM accepted since the last accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (start_acc_s) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if (wr_acc_s) begin
            checksum_r <= checksum_r + hold_r;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign buf_re     = buf_re_r;
    assign dram_we    = dram_we_r;
    assign buf_addr   = src_r;
    assign dram_addr  = dst_r;
    assign dram_wdata = hold_r;

endmodule

// File: tb/tb_dma_writeback_engine.sv
// Self-checking bench for dma_writeback_engine: directed command table,
// reset-abort sequence and randomized commands against a per-cycle model.
module tb_dma_writeback_engine;

    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] xfer_len;
    logic        busy;
    logic        done;
    logic [31:0] buf_addr;
    logic        buf_re;
    logic [15:0] buf_rdata;
    logic [31:0] dram_addr;
    logic [15:0] dram_wdata;
    logic        dram_we;
    logic        dram_ready;
`ifdef DMA_WB_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    dma_writeback_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done),
        .buf_addr(buf_addr), .buf_re(buf_re), .buf_rdata(buf_rdata),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
`ifdef DMA_WB_CHECKSUM_EN
        .checksum(checksum),
`endif
        .dram_ready(dram_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] over [logic [31:0]];
    bit          ready_tr  [MAXC];
    bit          exp_busy  [MAXC];
    bit          exp_done  [MAXC];
    bit          exp_re    [MAXC];
    bit          exp_we    [MAXC];
    logic [31:0] exp_raddr [MAXC];
    logic [31:0] exp_waddr [MAXC];
    logic [15:0] exp_wdata [MAXC];
    int          done_cyc;
    logic [15:0] exp_sum;
    int          got_wr;
    int          got_done;
    int          got_done_cyc;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          restart_cyc;
        int          stall_lo;
        int          stall_hi;
        int          exp_done_cyc;
        int          exp_wr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] memv(input logic [31:0] a);
        if (over.exists(a)) return over[a];
        return a[15:0] ^ a[31:16] ^ 16'h5AC3;
    endfunction

    // Expected per-cycle behaviour from the word timing rules and the ready trace
    task automatic build_model(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        int t;
        int c;
        for (int i = 0; i < MAXC; i++) begin
            exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_re[i] = 1'b0; exp_we[i] = 1'b0;
            exp_raddr[i] = 32'h0; exp_waddr[i] = 32'h0; exp_wdata[i] = 16'h0;
        end
        exp_sum = 16'h0;
        t = 3;
        c = 0;
        for (int k = 0; k < int'(l); k++) begin
            exp_re[t-2]    = 1'b1;
            exp_raddr[t-2] = s + k;
            c = t;
            while (!ready_tr[c] && c < MAXC - 8) c++;
            for (int j = t; j <= c; j++) begin
                exp_we[j]    = 1'b1;
                exp_waddr[j] = d + k;
                exp_wdata[j] = memv(s + k);
            end
            exp_sum = exp_sum + memv(s + k);
            t = c + 3;
        end
        done_cyc = (l == 16'd0) ? 1 : c + 1;
        exp_done[done_cyc] = 1'b1;
        for (int i = 1; i <= done_cyc; i++) exp_busy[i] = 1'b1;
    endtask

    // Issue one command and compare every cycle until one cycle past done
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input int restart_cyc, input int abort_cyc);
        logic        rd_pend;
        logic [31:0] rd_a;
        build_model(s, d, l);
        got_wr = 0; got_done = 0; got_done_cyc = -1;
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; xfer_len = l; start = 1'b1;
        dram_ready = 1'b1; buf_rdata = 16'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 1; r <= done_cyc + 1; r++) begin
            dram_ready = ready_tr[r];
            if (r == restart_cyc) begin
                start = 1'b1; src_addr = 32'h500; dst_addr = 32'h900; xfer_len = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("busy", busy, exp_busy[r]);
            chk("done", done, exp_done[r]);
            chk("buf_re", buf_re, exp_re[r]);
            if (exp_re[r]) chk("buf_addr", buf_addr, exp_raddr[r]);
            chk("dram_we", dram_we, exp_we[r]);
            if (exp_we[r]) begin
                chk("dram_addr", dram_addr, exp_waddr[r]);
                chk("dram_wdata", dram_wdata, exp_wdata[r]);
            end
`ifdef DMA_WB_CHECKSUM_EN
            if (r >= done_cyc) chk("checksum", checksum, exp_sum);
`endif
            if (dram_we && dram_ready && r != abort_cyc) got_wr++;
            if (done) begin
                got_done++;
                if (got_done_cyc < 0) got_done_cyc = r;
            end
            rd_pend = buf_re;
            rd_a    = buf_addr;
            if (r == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {busy, done, buf_re, dram_we, buf_addr, dram_addr, dram_wdata}, 128'h0);
                return;
            end
            @(posedge clk); #1;
            buf_rdata = rd_pend ? memv(rd_a) : 16'hDEAD;
        end
    endtask

    task automatic fill_ready(input int lo, input int hi);
        for (int i = 0; i < MAXC; i++) ready_tr[i] = !(i >= lo && i <= hi);
    endtask

    initial begin
        over[32'h10]  = 16'h00A1; over[32'h11]  = 16'h00B2;
        over[32'h12]  = 16'h00C3; over[32'h13]  = 16'h00D4;
        over[32'h300] = 16'hFFFF; over[32'h301] = 16'h0002;

        vecs[0] = '{32'h10, 32'h2000, 16'd4, -1, -1, -1, 13, 4};
        vecs[1] = '{32'h10, 32'h2000, 16'd4, -1,  6, 10, 18, 4};
        vecs[2] = '{32'h10, 32'h2000, 16'd0, -1, -1, -1,  1, 0};
        vecs[3] = '{32'h10, 32'h2000, 16'd4,  5, -1, -1, 13, 4};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 16'd3, -1, -1, -1, 10, 3};
        vecs[5] = '{32'h300, 32'h40, 16'd2, -1, -1, -1, 7, 2};

        rst_n = 1'b0; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0;
        xfer_len = 16'h0; buf_rdata = 16'h0; dram_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero",
            {busy, done, buf_re, dram_we, buf_addr, dram_addr, dram_wdata}, 128'h0);
`ifdef DMA_WB_CHECKSUM_EN
        chk("reset_checksum", checksum, 16'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_ready(vecs[i].stall_lo, vecs[i].stall_hi);
            run_cmd(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].restart_cyc, -1);
            chk($sformatf("vec%0d_writes", i), got_wr, vecs[i].exp_wr);
            chk($sformatf("vec%0d_done_pulses", i), got_done, 1);
            chk($sformatf("vec%0d_done_cycle", i), got_done_cyc, vecs[i].exp_done_cyc);
        end

        // Reset during the WR cycle of word 2 (stalled so it is not accepted)
        fill_ready(9, 9);
        run_cmd(32'h10, 32'h2000, 16'd4, -1, 9);
        chk("abort_writes", got_wr, 2);
        chk("abort_done_pulses", got_done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_held_zero", {busy, done, buf_re, dram_we}, 128'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_ready(-1, -1);
        run_cmd(32'h10, 32'h2000, 16'd4, -1, -1);
        chk("post_abort_writes", got_wr, 4);
        chk("post_abort_done_cycle", got_done_cyc, 13);

        for (int n = 0; n < 15; n++) begin
            logic [31:0] s;
            logic [31:0] d;
            logic [15:0] l;
            s = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) s = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            l = 16'($urandom_range(0, 12));
            for (int i = 0; i < MAXC; i++) ready_tr[i] = (i >= 400) || ($urandom_range(0, 3) != 0);
            run_cmd(s, d, l, ($urandom_range(0, 1) == 1) ? 4 : -1, -1);
            chk("rand_writes", got_wr, int'(l));
            chk("rand_done_pulses", got_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
